// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and the drain FSM state type for the register write scoreboard.
package reg_scoreboard_pkg;
  localparam int         NREGS  = 32;
  localparam logic [4:0] ZR_IDX = 5'd31;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} drain_state_e;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode / write-back / drain handshake bundle between the core and the scoreboard.
interface reg_scoreboard_if #(parameter int CNT_W = 2);
  logic             id_valid;
  logic [4:0]       id_ra1, id_ra2;
  logic             id_use1, id_use2;
  logic [4:0]       id_wa;
  logic             id_we;
  logic             wb_we;
  logic [4:0]       wb_wa;
  logic             drain_req;
  logic             stall;
  logic             issue;
  logic [31:0]      busy;
  logic [CNT_W+4:0] inflight;
  logic             drain_ack;
  logic             err_underflow;

  modport master (
    output id_valid, id_ra1, id_ra2, id_use1, id_use2, id_wa, id_we,
           wb_we, wb_wa, drain_req,
    input  stall, issue, busy, inflight, drain_ack, err_underflow
  );

  modport slave (
    input  id_valid, id_ra1, id_ra2, id_use1, id_use2, id_wa, id_we,
           wb_we, wb_wa, drain_req,
    output stall, issue, busy, inflight, drain_ack, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-write counter. Simultaneous inc/dec cancel; the
// counter never wraps in either direction. up/down report an actual step.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             max,
  output logic             underflow,
  output logic             up,
  output logic             down
);
  assign zero      = (cnt == '0);
  assign max       = &cnt;
  assign up        = inc & ~dec & ~max;
  assign down      = dec & ~inc & ~zero;
  assign underflow = dec & ~inc & zero;

  // count step
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (up)   cnt <= cnt + CNT_W'(1);
    else if (down) cnt <= cnt - CNT_W'(1);
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Register-file write scoreboard: per-register in-flight counters, RAW and
// saturation stall, and a drain handshake.
// Optional macro SCOREBOARD_BYPASS_EN: the register file writes through, so a
// reader of a register whose last pending write retires this cycle does not stall.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);
  localparam int IW = CNT_W + 5;

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0] inc, dec, zero, max, uflow, up, down, rd_busy;
  logic             wr_trk, rt_trk, haz1, haz2, sat;
  logic [IW-1:0]    inflight_q;
  logic             err_q;
  drain_state_e     state, state_nxt;

  assign wr_trk = sb.id_we & (sb.id_wa != ZR_IDX);
  assign rt_trk = sb.wb_we & (sb.wb_wa != ZR_IDX);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    assign inc[r] = sb.issue & wr_trk & (sb.id_wa == 5'(r));
    assign dec[r] = rt_trk & (sb.wb_wa == 5'(r));
    if (r == NREGS - 1) begin : g_zr
      // XZR is never tracked
      assign cnt[r]   = '0;
      assign zero[r]  = 1'b1;
      assign max[r]   = 1'b0;
      assign uflow[r] = 1'b0;
      assign up[r]    = 1'b0;
      assign down[r]  = 1'b0;
    end else begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk), .reset(reset), .inc(inc[r]), .dec(dec[r]), .cnt(cnt[r]),
        .zero(zero[r]), .max(max[r]), .underflow(uflow[r]),
        .up(up[r]), .down(down[r])
      );
    end
`ifdef SCOREBOARD_BYPASS_EN
    // last pending write landing this cycle is forwarded by the register file
    assign rd_busy[r] = ~zero[r] &
                        ~((cnt[r] == CNT_W'(1)) & sb.wb_we & (sb.wb_wa == 5'(r)));
`else
    assign rd_busy[r] = ~zero[r];
`endif
  end

  assign haz1  = sb.id_use1 & (sb.id_ra1 != ZR_IDX) & rd_busy[sb.id_ra1];
  assign haz2  = sb.id_use2 & (sb.id_ra2 != ZR_IDX) & rd_busy[sb.id_ra2];
  // uses the registered count, so a same-cycle retire does not relieve it
  assign sat   = wr_trk & max[sb.id_wa];

  assign sb.stall         = sb.id_valid & (haz1 | haz2 | sat | (state == DRAIN));
  assign sb.issue         = sb.id_valid & ~sb.stall;
  assign sb.busy          = ~zero;
  assign sb.inflight      = inflight_q;
  assign sb.drain_ack     = (state == DONE);
  assign sb.err_underflow = err_q;

  // total pending count moves by the net step of at most one up and one down
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   inflight_q <= '0;
    else if ((|up) && !(|down))  inflight_q <= inflight_q + IW'(1);
    else if ((|down) && !(|up))  inflight_q <= inflight_q - IW'(1);
  end

  // sticky underflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (|uflow)  err_q <= 1'b1;
  end

  // drain FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // drain FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sb.drain_req) state_nxt = DRAIN;
      DRAIN:   if (inflight_q == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard (CNT_W = 2).
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   miss = 0;

  reg_scoreboard_if #(.CNT_W(2)) sbi();
  reg_scoreboard #(.CNT_W(2)) dut (.clk(clk), .reset(reset), .sb(sbi));

  always #5 clk = ~clk;

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic BYP_STALL = 1'b0;
`else
  localparam logic BYP_STALL = 1'b1;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    sbi.id_valid = 0; sbi.id_ra1 = 0; sbi.id_ra2 = 0; sbi.id_use1 = 0;
    sbi.id_use2 = 0; sbi.id_wa = 0; sbi.id_we = 0; sbi.wb_we = 0;
    sbi.wb_wa = 0; sbi.drain_req = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a);
    sbi.id_valid = 1; sbi.id_we = 1; sbi.id_wa = a;
  endtask

  task automatic rt(input logic [4:0] a);
    sbi.wb_we = 1; sbi.wb_wa = a;
  endtask

  initial begin
    clr();
    sbi.id_valid = 1;
    #2;
    chk("rst_stall", 64'(sbi.stall), 64'(0));
    chk("rst_issue", 64'(sbi.issue), 64'(1));
    chk("rst_busy", 64'(sbi.busy), 64'(0));
    chk("rst_inflight", 64'(sbi.inflight), 64'(0));
    chk("rst_ack", 64'(sbi.drain_ack), 64'(0));
    chk("rst_err", 64'(sbi.err_underflow), 64'(0));
    clr();
    @(negedge clk) reset = 0;
    tick();

    // issue X1, then a dependent read
    wr(1); #1;
    chk("x1_issue", 64'(sbi.issue), 64'(1));
    tick(); clr(); #1;
    chk("x1_busy", 64'(sbi.busy), 64'h2);
    chk("x1_inflight", 64'(sbi.inflight), 64'(1));
    sbi.id_valid = 1; sbi.id_use1 = 1; sbi.id_ra1 = 1; #1;
    chk("raw_stall", 64'(sbi.stall), 64'(1));
    chk("raw_issue", 64'(sbi.issue), 64'(0));
    rt(1); #1;
    chk("wb_same_cycle_stall", 64'(sbi.stall), 64'(BYP_STALL));
    tick();
    sbi.wb_we = 0; #1;
    chk("wb_next_stall", 64'(sbi.stall), 64'(0));
    chk("wb_busy", 64'(sbi.busy), 64'(0));
    chk("wb_inflight", 64'(sbi.inflight), 64'(0));
    clr();

    // saturation on X5
    for (int i = 0; i < 3; i++) begin
      wr(5); tick();
    end
    clr(); #1;
    chk("sat_inflight3", 64'(sbi.inflight), 64'(3));
    chk("sat_busy", 64'(sbi.busy), 64'h20);
    wr(5); #1;
    chk("sat_stall", 64'(sbi.stall), 64'(1));
    rt(5); #1;
    chk("sat_stall_with_retire", 64'(sbi.stall), 64'(1));
    tick();
    sbi.wb_we = 0; #1;
    chk("sat_after_retire", 64'(sbi.inflight), 64'(2));
    chk("sat_fourth_ok", 64'(sbi.stall), 64'(0));
    tick(); #1;
    chk("sat_inflight_back3", 64'(sbi.inflight), 64'(3));
    chk("sat_stall_again", 64'(sbi.stall), 64'(1));
    clr();
    for (int i = 0; i < 3; i++) begin
      rt(5); tick();
    end
    clr(); #1;
    chk("sat_drained", 64'(sbi.inflight), 64'(0));
    chk("sat_no_err", 64'(sbi.err_underflow), 64'(0));

    // XZR is untracked
    wr(31); sbi.id_use1 = 1; sbi.id_ra1 = 31; #1;
    chk("xzr_stall", 64'(sbi.stall), 64'(0));
    tick(); clr(); #1;
    chk("xzr_busy", 64'(sbi.busy), 64'(0));
    chk("xzr_inflight", 64'(sbi.inflight), 64'(0));
    rt(31); tick(); clr(); #1;
    chk("xzr_retire_err", 64'(sbi.err_underflow), 64'(0));

    // underflow on X7
    rt(7); tick(); clr(); #1;
    chk("uflow_err", 64'(sbi.err_underflow), 64'(1));
    chk("uflow_inflight", 64'(sbi.inflight), 64'(0));
    wr(2); tick();
    wr(3); tick(); clr(); #1;
    chk("uflow_sticky", 64'(sbi.err_underflow), 64'(1));
    chk("two_inflight", 64'(sbi.inflight), 64'(2));
    chk("two_busy", 64'(sbi.busy), 64'hC);

    // drain with two pending writes
    sbi.drain_req = 1; tick(); sbi.drain_req = 0;
    wr(4); #1;
    chk("drain_block_stall", 64'(sbi.stall), 64'(1));
    chk("drain_block_issue", 64'(sbi.issue), 64'(0));
    clr();
    rt(2); sbi.drain_req = 1; tick();
    clr(); rt(3); tick(); clr(); #1;
    chk("drain_last_inflight", 64'(sbi.inflight), 64'(0));
    chk("drain_ack_early", 64'(sbi.drain_ack), 64'(0));
    wr(4); #1;
    chk("drain_still_blocked", 64'(sbi.stall), 64'(1));
    clr();
    tick();
    chk("drain_ack", 64'(sbi.drain_ack), 64'(1));
    wr(4); #1;
    chk("done_not_blocked", 64'(sbi.stall), 64'(0));
    clr();
    tick();
    chk("ack_pulse_end", 64'(sbi.drain_ack), 64'(0));
    tick();
    chk("no_second_ack", 64'(sbi.drain_ack), 64'(0));

    // reset in the middle of a drain
    wr(6); tick(); clr();
    sbi.drain_req = 1; tick(); sbi.drain_req = 0;
    #2 reset = 1; #1;
    chk("mid_rst_ack", 64'(sbi.drain_ack), 64'(0));
    chk("mid_rst_inflight", 64'(sbi.inflight), 64'(0));
    chk("mid_rst_busy", 64'(sbi.busy), 64'(0));
    chk("mid_rst_err", 64'(sbi.err_underflow), 64'(0));
    @(negedge clk) reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_ack", 64'(sbi.drain_ack), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
